memory_stage: RTL and testbench
===============================

# memory_stage

Pipeline MEM stage of the LEGv8 pipelined processor. It consumes the EX/MEM signals produced by `Execute` and resolves branches toward fetch. It runs a request/ready handshake against data memory, stalling upstream stages while an access is outstanding. It also owns the MEM/WB pipeline register feeding write-back.

## Interface
- Parameters: none. Data and address are fixed at 64 bits and the register index at 5 bits.
- `clk` input 1 — single clock; all state updates on posedge.
- `reset` input 1 — synchronous, active-high.
- `RegWrite_MEM, Branch_MEM, Uncondbranch_MEM, MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM` input 1 each — control bits from EX/MEM.
- `ALUzero_MEM` input 1 — ALU zero flag.
- `RD_MEM` input 5 — destination register.
- `ALUout_MEM` input 64 — ALU result / memory address.
- `RegOutB_MEM` input 64 — store data.
- `PCtarget_MEM` input 64 — branch target.
- `PCSrc_MEM` output 1 — take branch: `Uncondbranch_MEM | (Branch_MEM & ALUzero_MEM)`.
- `PCtarget_IF` output 64 — equals `PCtarget_MEM`.
- `stall_MEM` output 1 — freeze PC, IF/ID, ID/EX and EX/MEM.
- `dmem_req` output 1, `dmem_we` output 1, `dmem_addr` output 64, `dmem_wdata` output 64 — memory request.
- `dmem_rdata` input 64, `dmem_ready` input 1 — memory response.
- `RegWrite_WB, Mem2Reg_WB` output 1 each; `RD_WB` output 5; `ALUout_WB, MemData_WB` output 64 — MEM/WB register.

## Operation
- A memory op is `MemRead_MEM | MemWrite_MEM`. If both are set, the write wins: `dmem_we`=1 and no read data is captured.
- FSM states are IDLE, BUSY and DONE.
- IDLE, no memory op:
  - `stall_MEM`=0.
  - MEM/WB loads `RegWrite`, `Mem2Reg`, `RD`, `ALUout`, and `MemData_WB`=0.
  - Stay in IDLE.
- IDLE, memory op:
  - `stall_MEM`=1 combinationally.
  - Register `dmem_addr`←`ALUout_MEM`, `dmem_wdata`←`RegOutB_MEM`, `dmem_we`←`MemWrite_MEM`, `dmem_req`←1.
  - MEM/WB loads a bubble (all fields 0).
  - Go to BUSY.
- BUSY:
  - `stall_MEM`=1, `dmem_req`=1; address, data and we are held stable.
  - MEM/WB loads a bubble.
  - On `dmem_ready`=1: capture `dmem_rdata` into a read buffer (load) or 0 (store), drop `dmem_req` at the same edge, go to DONE.
  - Otherwise stay in BUSY indefinitely.
- DONE:
  - `stall_MEM`=0.
  - MEM/WB loads control/RD/ALUout from the held inputs and `MemData_WB`← read buffer.
  - Go to IDLE unconditionally. DONE never starts a new access; the next instruction is evaluated in IDLE.
- Upstream holds all `_MEM` inputs constant whenever `stall_MEM`=1.
- `PCSrc_MEM` and `PCtarget_IF` are combinational and independent of the FSM. Upstream holds the branch inputs during a stall, so these stay valid throughout.

## Timing
- Reset:
  - FSM→IDLE.
  - `dmem_req`, `dmem_we`=0; `dmem_addr`, `dmem_wdata`=0.
  - All `_WB` outputs=0; read buffer=0.
  - Reset during BUSY abandons the access: `dmem_req` is low the cycle after the reset edge and any late `dmem_ready` is ignored.
- Non-memory instruction: 1 cycle; WB outputs are valid the edge after the inputs are presented.
- Memory instruction with `dmem_ready` asserted in the first BUSY cycle: 3 cycles (IDLE, BUSY, DONE). `stall_MEM` is high for 2 cycles; WB is valid after the DONE edge.
- Each extra BUSY cycle adds 1 cycle of latency and 1 cycle of stall.
- `dmem_ready` is sampled only in BUSY and ignored in IDLE and DONE.
- During stall cycles `RegWrite_WB`=0, so write-back never double-commits.

## Test plan
- **Reset:** hold `reset`=1 for 2 cycles with `MemWrite_MEM`=1 → all `_WB`=0, `dmem_req`=0, `stall_MEM`=0 after release until inputs are re-presented.
- **STUR:** `MemWrite`=1, `ALUout`=10, `RegOutB`=0x55, RD=14, ready tied high → `dmem_req`=1, we=1, addr=10, wdata=0x55 for one cycle. `stall_MEM` is high 2 cycles; then `RegWrite_WB`=0, `MemData_WB`=0.
- **LDUR with wait states:** `MemRead`=1, `RegWrite`=1, `Mem2Reg`=1, `ALUout`=0x20, RD=9, `dmem_ready` delayed 3 cycles, rdata=0xDEADBEEF → stall 4 cycles with addr stable at 0x20. Then `RegWrite_WB`=1, `RD_WB`=9, `MemData_WB`=0xDEADBEEF, `ALUout_WB`=0x20.
- **Branches:**
  - CBZ: `Branch`=1, `ALUzero`=1, `PCtarget`=0 → `PCSrc_MEM`=1, `PCtarget_IF`=0.
  - B: `Uncondbranch`=1, `PCtarget`=0xC → `PCSrc_MEM`=1, `PCtarget_IF`=0xC.
  - `Branch`=1, `ALUzero`=0 → `PCSrc_MEM`=0.
  - None of these stall.
- **ALU op then back-to-back load:** ADD (RD=3, ALUout=7) followed by LDUR → the ADD commits the next edge (`RD_WB`=3, `RegWrite_WB`=1), the load stall begins immediately, and no bubble precedes the ADD.
- **Reset mid-BUSY:** assert `reset` while `dmem_ready`=0, then raise ready → `dmem_req`=0 after the reset edge; WB stays 0 and no capture occurs.

Source files
------------

// File: rtl/memory_stage.sv
// LEGv8 MEM stage: branch resolve, data-memory req/ready handshake, MEM/WB register.
// Latency 1 cycle for non-memory ops, 3+N for memory ops (N = extra wait states); stalls upstream while an access is open.
module memory_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_MEM,
  input  logic        Branch_MEM,
  input  logic        Uncondbranch_MEM,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic        Mem2Reg_MEM,
  input  logic        ALUzero_MEM,
  input  logic [4:0]  RD_MEM,
  input  logic [63:0] ALUout_MEM,
  input  logic [63:0] RegOutB_MEM,
  input  logic [63:0] PCtarget_MEM,
  output logic        PCSrc_MEM,
  output logic [63:0] PCtarget_IF,
  output logic        stall_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        RegWrite_WB,
  output logic        Mem2Reg_WB,
  output logic [4:0]  RD_WB,
  output logic [63:0] ALUout_WB,
  output logic [63:0] MemData_WB
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem2reg;
    logic [4:0]  rd;
    logic [63:0] alu_out;
    logic [63:0] mem_data;
  } wb_t;

  state_t      state;
  wb_t         wb_q;
  logic [63:0] rd_buf;
  logic        mem_op;

  assign mem_op      = MemRead_MEM | MemWrite_MEM;
  assign PCSrc_MEM   = Uncondbranch_MEM | (Branch_MEM & ALUzero_MEM);
  assign PCtarget_IF = PCtarget_MEM;

  // Stall is raised in the same cycle a memory op is first seen so EX/MEM holds it.
  assign stall_MEM = (state == BUSY) || ((state == IDLE) && mem_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 64'd0;
      dmem_wdata <= 64'd0;
      rd_buf     <= 64'd0;
      wb_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite_MEM;
            dmem_addr  <= ALUout_MEM;
            dmem_wdata <= RegOutB_MEM;
            wb_q       <= '0;
            state      <= BUSY;
          end else begin
            wb_q <= '{reg_write: RegWrite_MEM, mem2reg: Mem2Reg_MEM, rd: RD_MEM,
                      alu_out: ALUout_MEM, mem_data: 64'd0};
          end
        end
        BUSY: begin
          wb_q <= '0;
          if (dmem_ready) begin
            // A write (including read+write) never returns data to write-back.
            rd_buf   <= dmem_we ? 64'd0 : dmem_rdata;
            dmem_req <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          wb_q  <= '{reg_write: RegWrite_MEM, mem2reg: Mem2Reg_MEM, rd: RD_MEM,
                     alu_out: ALUout_MEM, mem_data: rd_buf};
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign RegWrite_WB = wb_q.reg_write;
  assign Mem2Reg_WB  = wb_q.mem2reg;
  assign RD_WB       = wb_q.rd;
  assign ALUout_WB   = wb_q.alu_out;
  assign MemData_WB  = wb_q.mem_data;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized instruction stream vs. a behavioural model.
module tb_memory_stage;

  logic        clk;
  logic        reset;
  logic        RegWrite_MEM, Branch_MEM, Uncondbranch_MEM, MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM, ALUzero_MEM;
  logic [4:0]  RD_MEM;
  logic [63:0] ALUout_MEM, RegOutB_MEM, PCtarget_MEM;
  logic        PCSrc_MEM;
  logic [63:0] PCtarget_IF;
  logic        stall_MEM;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        RegWrite_WB, Mem2Reg_WB;
  logic [4:0]  RD_WB;
  logic [63:0] ALUout_WB, MemData_WB;

  int checks;
  int failures;

  memory_stage dut (
    .clk(clk), .reset(reset),
    .RegWrite_MEM(RegWrite_MEM), .Branch_MEM(Branch_MEM), .Uncondbranch_MEM(Uncondbranch_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .Mem2Reg_MEM(Mem2Reg_MEM),
    .ALUzero_MEM(ALUzero_MEM), .RD_MEM(RD_MEM), .ALUout_MEM(ALUout_MEM),
    .RegOutB_MEM(RegOutB_MEM), .PCtarget_MEM(PCtarget_MEM),
    .PCSrc_MEM(PCSrc_MEM), .PCtarget_IF(PCtarget_IF), .stall_MEM(stall_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .RegWrite_WB(RegWrite_WB), .Mem2Reg_WB(Mem2Reg_WB), .RD_WB(RD_WB),
    .ALUout_WB(ALUout_WB), .MemData_WB(MemData_WB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic present(input logic rw, input logic br, input logic ub, input logic mr,
                         input logic mw, input logic m2r, input logic z, input logic [4:0] rd,
                         input logic [63:0] alu, input logic [63:0] rob, input logic [63:0] pct);
    RegWrite_MEM = rw; Branch_MEM = br; Uncondbranch_MEM = ub; MemRead_MEM = mr;
    MemWrite_MEM = mw; Mem2Reg_MEM = m2r; ALUzero_MEM = z; RD_MEM = rd;
    ALUout_MEM = alu; RegOutB_MEM = rob; PCtarget_MEM = pct;
  endtask

  // Plays the memory side for one presented instruction and reports what it observed.
  // Starts just after a rising edge with the instruction on the inputs; returns just after
  // the edge that commits it to MEM/WB. stalls = -1 if the stage never released the stall.
  task automatic exec_instr(input int wait_n, input logic noise, input logic [63:0] rdata,
                            output int stalls, output int req_cycles,
                            output logic [63:0] o_addr, output logic [63:0] o_wdata,
                            output logic o_we, output logic hold_ok, output logic pc_ok);
    logic done;
    stalls = 0; req_cycles = 0; hold_ok = 1'b1; pc_ok = 1'b1;
    o_addr = '0; o_wdata = '0; o_we = 1'b0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      #4;
      if (PCSrc_MEM !== (Uncondbranch_MEM | (Branch_MEM & ALUzero_MEM)) || PCtarget_IF !== PCtarget_MEM)
        pc_ok = 1'b0;
      if (stall_MEM === 1'b1) begin
        stalls++;
        if (dmem_req === 1'b1) begin
          if (req_cycles == 0) begin
            o_addr = dmem_addr; o_we = dmem_we; o_wdata = dmem_wdata;
          end else if (dmem_addr !== o_addr || dmem_we !== o_we || dmem_wdata !== o_wdata) begin
            hold_ok = 1'b0;
          end
          if (RegWrite_WB !== 1'b0) hold_ok = 1'b0;
          req_cycles++;
          dmem_ready = (req_cycles == wait_n + 1);
          dmem_rdata = dmem_ready ? rdata : {$urandom, $urandom};
        end else begin
          dmem_ready = noise;
          dmem_rdata = {$urandom, $urandom};
        end
      end else begin
        if (dmem_req !== 1'b0) hold_ok = 1'b0;
        dmem_ready = noise;
        dmem_rdata = {$urandom, $urandom};
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    dmem_ready = 1'b0;
    if (!done) stalls = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    present(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 64'h40, 64'h99, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({RegWrite_WB, Mem2Reg_WB, RD_WB, ALUout_WB, MemData_WB} !== '0) begin
      failures++;
      $display("FAIL reset_wb: got rw=%b m2r=%b rd=%0d alu=%h md=%h want all zero",
               RegWrite_WB, Mem2Reg_WB, RD_WB, ALUout_WB, MemData_WB);
    end
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_dmem: got req=%b we=%b addr=%h wdata=%h want all zero",
               dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    reset = 1'b0;
    present(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0);
    #4;
    checks++;
    if (stall_MEM !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall: got %b want 0", stall_MEM);
    end
    @(posedge clk); #1;
    checks++;
    if (dmem_req !== 1'b0 || RegWrite_WB !== 1'b0 || MemData_WB !== 64'h0) begin
      failures++;
      $display("FAIL reset_release: got req=%b rw=%b md=%h want 0 0 0", dmem_req, RegWrite_WB, MemData_WB);
    end
  endtask

  task automatic test_stur;
    int st, rc;
    logic [63:0] a, wd;
    logic we, hok, pok;
    present(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd14, 64'd10, 64'h55, 64'h100);
    exec_instr(0, 1'b1, 64'h1234, st, rc, a, wd, we, hok, pok);
    checks++;
    if (st !== 2 || rc !== 1) begin
      failures++;
      $display("FAIL stur_timing: got stall=%0d req=%0d want 2 1", st, rc);
    end
    checks++;
    if (a !== 64'd10 || we !== 1'b1 || wd !== 64'h55 || hok !== 1'b1) begin
      failures++;
      $display("FAIL stur_req: got addr=%h we=%b wdata=%h hold=%b want a 1 55 1", a, we, wd, hok);
    end
    checks++;
    if (RegWrite_WB !== 1'b0 || MemData_WB !== 64'h0 || ALUout_WB !== 64'd10 || RD_WB !== 5'd14) begin
      failures++;
      $display("FAIL stur_wb: got rw=%b md=%h alu=%h rd=%0d want 0 0 a 14", RegWrite_WB, MemData_WB, ALUout_WB, RD_WB);
    end
  endtask

  task automatic test_ldur_wait;
    int st, rc;
    logic [63:0] a, wd;
    logic we, hok, pok;
    present(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 64'h20, 64'h77, 64'h0);
    exec_instr(2, 1'b0, 64'hDEADBEEF, st, rc, a, wd, we, hok, pok);
    checks++;
    if (st !== 4 || rc !== 3) begin
      failures++;
      $display("FAIL ldur_timing: got stall=%0d req=%0d want 4 3", st, rc);
    end
    checks++;
    if (a !== 64'h20 || we !== 1'b0 || hok !== 1'b1) begin
      failures++;
      $display("FAIL ldur_req: got addr=%h we=%b hold=%b want 20 0 1", a, we, hok);
    end
    checks++;
    if (RegWrite_WB !== 1'b1 || Mem2Reg_WB !== 1'b1 || RD_WB !== 5'd9 ||
        MemData_WB !== 64'hDEADBEEF || ALUout_WB !== 64'h20) begin
      failures++;
      $display("FAIL ldur_wb: got rw=%b m2r=%b rd=%0d md=%h alu=%h want 1 1 9 deadbeef 20",
               RegWrite_WB, Mem2Reg_WB, RD_WB, MemData_WB, ALUout_WB);
    end
  endtask

  task automatic test_branches;
    logic        br_t[3]  = '{1'b1, 1'b0, 1'b1};
    logic        ub_t[3]  = '{1'b0, 1'b1, 1'b0};
    logic        z_t[3]   = '{1'b1, 1'b0, 1'b0};
    logic [63:0] pct_t[3] = '{64'h0, 64'hC, 64'h80};
    logic        exp_t[3] = '{1'b1, 1'b1, 1'b0};
    int st, rc;
    logic [63:0] a, wd;
    logic we, hok, pok;
    for (int i = 0; i < 3; i++) begin
      present(1'b0, br_t[i], ub_t[i], 1'b0, 1'b0, 1'b0, z_t[i], 5'd0, 64'h5, 64'h0, pct_t[i]);
      #1;
      checks++;
      if (PCSrc_MEM !== exp_t[i] || PCtarget_IF !== pct_t[i]) begin
        failures++;
        $display("FAIL branch_%0d: got pcsrc=%b target=%h want %b %h", i, PCSrc_MEM, PCtarget_IF, exp_t[i], pct_t[i]);
      end
      exec_instr(0, 1'b0, 64'h0, st, rc, a, wd, we, hok, pok);
      checks++;
      if (st !== 0 || pok !== 1'b1) begin
        failures++;
        $display("FAIL branch_nostall_%0d: got stall=%0d pc_ok=%b want 0 1", i, st, pok);
      end
    end
  endtask

  task automatic test_back_to_back;
    int st, rc;
    logic [63:0] a, wd;
    logic we, hok, pok;
    present(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 64'd7, 64'h0, 64'h0);
    exec_instr(0, 1'b0, 64'h0, st, rc, a, wd, we, hok, pok);
    checks++;
    if (st !== 0 || RegWrite_WB !== 1'b1 || RD_WB !== 5'd3 || ALUout_WB !== 64'd7 || MemData_WB !== 64'h0) begin
      failures++;
      $display("FAIL b2b_add: got stall=%0d rw=%b rd=%0d alu=%h md=%h want 0 1 3 7 0",
               st, RegWrite_WB, RD_WB, ALUout_WB, MemData_WB);
    end
    present(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 64'h30, 64'h0, 64'h0);
    #1;
    checks++;
    if (stall_MEM !== 1'b1 || RD_WB !== 5'd3) begin
      failures++;
      $display("FAIL b2b_load_start: got stall=%b rd_wb=%0d want 1 3", stall_MEM, RD_WB);
    end
    exec_instr(1, 1'b0, 64'hCAFE, st, rc, a, wd, we, hok, pok);
    checks++;
    if (st !== 3 || RD_WB !== 5'd4 || MemData_WB !== 64'hCAFE || RegWrite_WB !== 1'b1) begin
      failures++;
      $display("FAIL b2b_load: got stall=%0d rd=%0d md=%h rw=%b want 3 4 cafe 1", st, RD_WB, MemData_WB, RegWrite_WB);
    end
  endtask

  task automatic test_reset_busy;
    present(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 64'h50, 64'h0, 64'h0);
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dmem_req !== 1'b1) begin
      failures++;
      $display("FAIL rbusy_req_up: got %b want 1", dmem_req);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    present(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0);
    checks++;
    if (dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL rbusy_req_drop: got %b want 0", dmem_req);
    end
    dmem_ready = 1'b1;
    dmem_rdata = 64'hBAD;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (dmem_req !== 1'b0 || stall_MEM !== 1'b0 ||
          {RegWrite_WB, Mem2Reg_WB, RD_WB, ALUout_WB, MemData_WB} !== '0) begin
        failures++;
        $display("FAIL rbusy_idle_%0d: got req=%b stall=%b rw=%b rd=%0d md=%h want 0 0 0 0 0",
                 i, dmem_req, stall_MEM, RegWrite_WB, RD_WB, MemData_WB);
      end
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_random(input int n);
    int st, rc, wait_n, exp_st;
    logic [63:0] a, wd, alu, rob, pct, rdata, exp_md;
    logic we, hok, pok, mem, noise;
    logic [31:0] r;
    for (int k = 0; k < n; k++) begin
      r      = $urandom;
      alu    = {$urandom, $urandom};
      rob    = {$urandom, $urandom};
      pct    = {$urandom, $urandom};
      rdata  = {$urandom, $urandom};
      wait_n = $urandom_range(0, 3);
      noise  = r[12];
      present(r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[11:7], alu, rob, pct);
      mem    = r[3] | r[4];
      exp_st = mem ? wait_n + 2 : 0;
      exp_md = (mem && !r[4]) ? rdata : 64'h0;
      exec_instr(wait_n, noise, rdata, st, rc, a, wd, we, hok, pok);
      checks++;
      if (st !== exp_st || rc !== (mem ? wait_n + 1 : 0) || hok !== 1'b1 || pok !== 1'b1) begin
        failures++;
        $display("FAIL rand_%0d_timing: got stall=%0d req=%0d hold=%b pc=%b want %0d %0d 1 1",
                 k, st, rc, hok, pok, exp_st, mem ? wait_n + 1 : 0);
      end
      if (mem) begin
        checks++;
        if (a !== alu || we !== r[4] || wd !== rob) begin
          failures++;
          $display("FAIL rand_%0d_req: got addr=%h we=%b wdata=%h want %h %b %h", k, a, we, wd, alu, r[4], rob);
        end
      end
      checks++;
      if (RegWrite_WB !== r[0] || Mem2Reg_WB !== r[5] || RD_WB !== r[11:7] ||
          ALUout_WB !== alu || MemData_WB !== exp_md) begin
        failures++;
        $display("FAIL rand_%0d_wb: got rw=%b m2r=%b rd=%0d alu=%h md=%h want %b %b %0d %h %h",
                 k, RegWrite_WB, Mem2Reg_WB, RD_WB, ALUout_WB, MemData_WB, r[0], r[5], r[11:7], alu, exp_md);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 64'h0;
    present(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0);
    test_reset;
    test_stur;
    test_ldur_wait;
    test_branches;
    test_back_to_back;
    test_reset_busy;
    test_random(60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
